// File: rtl/rename_table_if.sv
`default_nettype none
// ============================================================================
// Module      : rename_table_if
// Description : Decode, allocator, dispatch and commit signals of the rename
//               table grouped into one bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface rename_table_if #(
  parameter int TAG_W = 6
) ();

  logic                  flush;

  logic [1:0]            in_valid;
  logic                  in_ready;
  logic [1:0]            in_wr;
  logic [1:0][4:0]       in_rd;
  logic [1:0][4:0]       in_rs1;
  logic [1:0][4:0]       in_rs2;

  logic [1:0]            rename;
  logic [1:0]            name_valid;
  logic [1:0][TAG_W-1:0] name;

  logic [1:0]            out_valid;
  logic                  out_ready;
  logic [1:0][TAG_W-1:0] out_rd_tag;
  logic [1:0][TAG_W-1:0] out_rs1_tag;
  logic [1:0]            out_rs1_ren;
  logic [1:0][TAG_W-1:0] out_rs2_tag;
  logic [1:0]            out_rs2_ren;

  logic                  commit_valid;
  logic [4:0]            commit_rd;
  logic [TAG_W-1:0]      commit_tag;

  // Driver side: decode, allocator, dispatch and commit stimulus.
  modport master (
    output flush, in_valid, in_wr, in_rd, in_rs1, in_rs2, name_valid, name,
           out_ready, commit_valid, commit_rd, commit_tag,
    input  in_ready, rename, out_valid, out_rd_tag, out_rs1_tag, out_rs1_ren,
           out_rs2_tag, out_rs2_ren
  );

  // Rename table side.
  modport slave (
    input  flush, in_valid, in_wr, in_rd, in_rs1, in_rs2, name_valid, name,
           out_ready, commit_valid, commit_rd, commit_tag,
    output in_ready, rename, out_valid, out_rd_tag, out_rs1_tag, out_rs1_ren,
           out_rs2_tag, out_rs2_ren
  );

endinterface
`default_nettype wire

// File: rtl/rename_table.sv
`default_nettype none
// ============================================================================
// Module      : rename_table
// Description : Two-wide register alias table with intra-group bypass,
//               commit retirement, flush and one registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module rename_table #(
  parameter int ARCH_REGS = 32,
  parameter int TAG_W     = 6
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  rename_table_if.slave   bus
);

  localparam int c_SLOTS = 2;

  // Alias table: tag storage needs no reset, only the mapped bits do.
  logic [TAG_W-1:0]            r_tag [ARCH_REGS];
  logic [ARCH_REGS-1:0]        r_mapped;

  logic [c_SLOTS-1:0]          r_out_valid;
  logic [c_SLOTS-1:0][TAG_W-1:0] r_out_rd_tag;
  logic [c_SLOTS-1:0][TAG_W-1:0] r_out_rs1_tag;
  logic [c_SLOTS-1:0][TAG_W-1:0] r_out_rs2_tag;
  logic [c_SLOTS-1:0]          r_out_rs1_ren;
  logic [c_SLOTS-1:0]          r_out_rs2_ren;

  logic [c_SLOTS-1:0]          w_need;
  logic                        w_live;
  logic                        w_in_ready;
  logic                        w_names_ok;
  logic                        w_accept;
  logic                        w_commit_hit;
  logic [c_SLOTS-1:0]          w_byp1;
  logic [c_SLOTS-1:0]          w_byp2;
  logic [c_SLOTS-1:0][TAG_W-1:0] w_rd_tag;
  logic [c_SLOTS-1:0][TAG_W-1:0] w_rs1_tag;
  logic [c_SLOTS-1:0][TAG_W-1:0] w_rs2_tag;
  logic [c_SLOTS-1:0]          w_rs1_ren;
  logic [c_SLOTS-1:0]          w_rs2_ren;

  // Reset and flush both freeze acceptance and clear speculative state.
  assign w_live     = reset_n & ~bus.flush;
  assign w_in_ready = ~(|r_out_valid) | bus.out_ready;
  assign w_names_ok = &(~w_need | bus.name_valid);
  assign w_accept   = (|bus.in_valid) & w_in_ready & w_live & w_names_ok;

  assign bus.in_ready = w_in_ready;
  assign bus.rename   = w_need & {c_SLOTS{w_in_ready & w_live}};

  // Slot 1 sees slot 0's destination as already renamed to name[0].
  assign w_byp1 = {w_need[0] & (bus.in_rs1[1] == bus.in_rd[0]), 1'b0};
  assign w_byp2 = {w_need[0] & (bus.in_rs2[1] == bus.in_rd[0]), 1'b0};

  for (genvar i = 0; i < c_SLOTS; i++) begin : g_slot
    assign w_need[i]   = bus.in_valid[i] & bus.in_wr[i] & (bus.in_rd[i] != 5'd0);
    assign w_rd_tag[i] = w_need[i] ? bus.name[i] : '0;

    assign w_rs1_ren[i] = w_byp1[i] |
                          ((bus.in_rs1[i] != 5'd0) & r_mapped[bus.in_rs1[i]]);
    assign w_rs1_tag[i] = w_byp1[i]                ? bus.name[0] :
                          (bus.in_rs1[i] != 5'd0)  ? r_tag[bus.in_rs1[i]] : '0;

    assign w_rs2_ren[i] = w_byp2[i] |
                          ((bus.in_rs2[i] != 5'd0) & r_mapped[bus.in_rs2[i]]);
    assign w_rs2_tag[i] = w_byp2[i]                ? bus.name[0] :
                          (bus.in_rs2[i] != 5'd0)  ? r_tag[bus.in_rs2[i]] : '0;
  end

  // A commit only retires the mapping if rd still points at the retiring tag.
  assign w_commit_hit = bus.commit_valid & (bus.commit_rd != 5'd0) &
                        r_mapped[bus.commit_rd] &
                        (r_tag[bus.commit_rd] == bus.commit_tag);

  // Later assignments win: commit clear, then slot 0 write, then slot 1.
  always_ff @(posedge clk) begin
    if (!w_live) begin
      r_mapped <= '0;
    end else begin
      if (w_commit_hit) begin
        r_mapped[bus.commit_rd] <= 1'b0;
      end
      if (w_accept && w_need[0]) begin
        r_mapped[bus.in_rd[0]] <= 1'b1;
      end
      if (w_accept && w_need[1]) begin
        r_mapped[bus.in_rd[1]] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && w_need[0]) begin
      r_tag[bus.in_rd[0]] <= bus.name[0];
    end
    if (w_accept && w_need[1]) begin
      r_tag[bus.in_rd[1]] <= bus.name[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_valid   <= '0;
      r_out_rd_tag  <= '0;
      r_out_rs1_tag <= '0;
      r_out_rs2_tag <= '0;
      r_out_rs1_ren <= '0;
      r_out_rs2_ren <= '0;
    end else if (bus.flush) begin
      r_out_valid <= '0;
    end else if (w_accept) begin
      r_out_valid   <= bus.in_valid;
      r_out_rd_tag  <= w_rd_tag;
      r_out_rs1_tag <= w_rs1_tag;
      r_out_rs2_tag <= w_rs2_tag;
      r_out_rs1_ren <= w_rs1_ren;
      r_out_rs2_ren <= w_rs2_ren;
    end else if (bus.out_ready) begin
      r_out_valid <= '0;
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.out_rd_tag  = r_out_rd_tag;
  assign bus.out_rs1_tag = r_out_rs1_tag;
  assign bus.out_rs2_tag = r_out_rs2_tag;
  assign bus.out_rs1_ren = r_out_rs1_ren;
  assign bus.out_rs2_ren = r_out_rs2_ren;

endmodule
`default_nettype wire
